pixel_frame_writer: RTL and testbench

- Write-side counterpart of the 35:1 pixel-select mux; owns the 5x7 one-bit pixel frame that the mux reads.
- Accepts single-pixel writes with the same 1-based row/column select encoding the mux decodes: row 1..5, column 1..7.
- Double-buffered: writes land in a back buffer; the front buffer drives the mux inputs and changes only on a commit (swap).
- Includes a sequential clear engine that walks every back-buffer pixel.

---
 rtl/pixel_frame_pkg.sv | 40 ++++
 rtl/pixel_frame_writer_addr_decode.sv | 31 +++
 rtl/pixel_frame_writer.sv | 169 ++++++++++++++++
 tb/tb_pixel_frame_writer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_frame_pkg.sv
// pixel_frame_pkg: constants and helpers shared by the 5x7 pixel frame
// writer and the 35:1 pixel-select mux that reads its frame.
//   ROWS/COLS/AW/NPIX : frame geometry and select-code width
//   state_t           : writer FSM states
//   pix_locate()      : 1-based (row,col) -> flat index plus legality bit
package pixel_frame_pkg;

  localparam int unsigned ROWS  = 5;
  localparam int unsigned COLS  = 7;
  localparam int unsigned AW    = 3;
  localparam int unsigned NPIX  = ROWS * COLS;
  localparam int unsigned IDX_W = $clog2(NPIX);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    COMMIT
  } state_t;

  typedef struct packed {
    logic             legal;
    logic [IDX_W-1:0] idx;
  } pix_loc_t;

  // Flat index is (row-1)*cols + (col-1); codes 0 and codes beyond the
  // geometry are illegal and return index 0.
  function automatic pix_loc_t pix_locate(input int unsigned row,
                                          input int unsigned col,
                                          input int unsigned rows,
                                          input int unsigned cols);
    pix_loc_t loc;
    loc.legal = (row != 0) && (row <= rows) && (col != 0) && (col <= cols);
    loc.idx   = '0;
    if (loc.legal) begin
      loc.idx = IDX_W'((row - 1) * cols + (col - 1));
    end
    return loc;
  endfunction

endpackage

// File: rtl/pixel_frame_writer_addr_decode.sv
// pixel_addr_decode: maps a 1-based (row,col) select pair to a one-hot
// pixel enable and a legal flag. Shared by the write/clear path and the
// optional readback path of pixel_frame_writer.
//   row, col : 1-based select codes
//   onehot   : one bit per pixel, all zero when the address is illegal
//   legal    : address lies inside the ROWS x COLS frame
module pixel_addr_decode
  import pixel_frame_pkg::*;
#(
  parameter int unsigned ROWS = pixel_frame_pkg::ROWS,
  parameter int unsigned COLS = pixel_frame_pkg::COLS,
  parameter int unsigned AW   = pixel_frame_pkg::AW
) (
  input  logic [AW-1:0]        row,
  input  logic [AW-1:0]        col,
  output logic [ROWS*COLS-1:0] onehot,
  output logic                 legal
);

  pix_loc_t loc;

  always_comb begin
    loc    = pix_locate(32'(row), 32'(col), ROWS, COLS);
    legal  = loc.legal;
    onehot = '0;
    if (loc.legal) begin
      onehot[loc.idx] = 1'b1;
    end
  end

endmodule

// File: rtl/pixel_frame_writer.sv
// pixel_frame_writer: double-buffered owner of the 5x7 one-bit pixel frame
// read by the 35:1 pixel-select mux.
//   CLK, RESET_N        : clock (rising edge), async active-low reset
//   WR_VALID/WR_READY   : single-pixel write handshake
//   WR_ROW/WR_COL       : 1-based row/column codes, WR_DATA : pixel value
//   CLR_REQ             : pulse, zero the back buffer one pixel per cycle
//   SWAP_REQ            : pulse, copy back buffer to FRAME atomically
//   FRAME               : front buffer, bit (r-1)*COLS+(c-1) is pixel (r,c)
//   BUSY                : clear running or commit pending/active
//   ERR / ERR_CLR       : sticky illegal-address flag and its clear
// Optional macro PIXEL_FRAME_READBACK_EN adds RD_ROW/RD_COL/RD_DATA, a
// registered back-buffer read port (illegal addresses read 0).
module pixel_frame_writer
#(
  parameter int unsigned ROWS = pixel_frame_pkg::ROWS,
  parameter int unsigned COLS = pixel_frame_pkg::COLS,
  parameter int unsigned AW   = pixel_frame_pkg::AW
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 WR_VALID,
  output logic                 WR_READY,
  input  logic [AW-1:0]        WR_ROW,
  input  logic [AW-1:0]        WR_COL,
  input  logic                 WR_DATA,
  input  logic                 CLR_REQ,
  input  logic                 SWAP_REQ,
  output logic [ROWS*COLS-1:0] FRAME,
  output logic                 BUSY,
  output logic                 ERR,
`ifdef PIXEL_FRAME_READBACK_EN
  input  logic [AW-1:0]        RD_ROW,
  input  logic [AW-1:0]        RD_COL,
  output logic                 RD_DATA,
`endif
  input  logic                 ERR_CLR
);

  import pixel_frame_pkg::*;

  localparam int unsigned NPIX_L = ROWS * COLS;

  state_t              state_q, state_d;
  logic [AW-1:0]       clr_row_q, clr_col_q;
  logic                swap_pend_q;
  logic                wr_ready_q;
  logic                err_q;
  logic [NPIX_L-1:0]   back_q, frame_q;

  logic [AW-1:0]       dec_row, dec_col;
  logic [NPIX_L-1:0]   dec_onehot;
  logic                dec_legal;
  logic                wr_fire;
  logic                clr_last;

  // One decoder serves both the write path and the clear walk; the two
  // never need it in the same cycle.
  assign dec_row = (state_q == CLEAR) ? clr_row_q : WR_ROW;
  assign dec_col = (state_q == CLEAR) ? clr_col_q : WR_COL;

  pixel_addr_decode #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) u_wr_decode (
    .row    (dec_row),
    .col    (dec_col),
    .onehot (dec_onehot),
    .legal  (dec_legal)
  );

  assign wr_fire  = WR_VALID & wr_ready_q;
  assign clr_last = (clr_row_q == AW'(ROWS)) && (clr_col_q == AW'(COLS));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (CLR_REQ) begin
          state_d = CLEAR;
        end else if (SWAP_REQ) begin
          state_d = COMMIT;
        end
      end
      CLEAR: begin
        if (clr_last) begin
          state_d = (swap_pend_q || SWAP_REQ) ? COMMIT : IDLE;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      clr_row_q   <= AW'(1);
      clr_col_q   <= AW'(1);
      swap_pend_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      err_q       <= 1'b0;
      back_q      <= '0;
      frame_q     <= '0;
    end else begin
      state_q <= state_d;
      // Registered ready tracks "next state is IDLE", so it equals
      // state==IDLE while still reading 0 throughout reset.
      wr_ready_q <= (state_d == IDLE);

      if (state_q == CLEAR) begin
        back_q <= back_q & ~dec_onehot;
        if (clr_col_q == AW'(COLS)) begin
          clr_col_q <= AW'(1);
          clr_row_q <= clr_row_q + AW'(1);
        end else begin
          clr_col_q <= clr_col_q + AW'(1);
        end
      end else begin
        clr_row_q <= AW'(1);
        clr_col_q <= AW'(1);
        if (wr_fire && dec_legal) begin
          back_q <= (back_q & ~dec_onehot) | (WR_DATA ? dec_onehot : '0);
        end
      end

      case (state_q)
        IDLE:    swap_pend_q <= CLR_REQ & SWAP_REQ;
        CLEAR:   swap_pend_q <= clr_last ? 1'b0 : (swap_pend_q | SWAP_REQ);
        default: swap_pend_q <= 1'b0;
      endcase

      if (state_q == COMMIT) begin
        frame_q <= back_q;
      end

      if (ERR_CLR) begin
        err_q <= 1'b0;
      end else if (wr_fire && !dec_legal) begin
        err_q <= 1'b1;
      end
    end
  end

  assign WR_READY = wr_ready_q;
  assign FRAME    = frame_q;
  assign BUSY     = (state_q != IDLE) | swap_pend_q;
  assign ERR      = err_q;

`ifdef PIXEL_FRAME_READBACK_EN
  logic [NPIX_L-1:0] rd_onehot;
  logic              rd_legal;
  logic              rd_data_q;

  pixel_addr_decode #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) u_rd_decode (
    .row    (RD_ROW),
    .col    (RD_COL),
    .onehot (rd_onehot),
    .legal  (rd_legal)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_data_q <= 1'b0;
    end else begin
      rd_data_q <= rd_legal & (|(back_q & rd_onehot));
    end
  end

  assign RD_DATA = rd_data_q;
`endif

endmodule

// File: tb/tb_pixel_frame_writer.sv
module tb_pixel_frame_writer;
  import pixel_frame_pkg::*;

  logic            CLK = 1'b0;
  logic            RESET_N;
  logic            WR_VALID, WR_READY, WR_DATA;
  logic [AW-1:0]   WR_ROW, WR_COL;
  logic            CLR_REQ, SWAP_REQ, BUSY, ERR, ERR_CLR;
  logic [NPIX-1:0] FRAME;
`ifdef PIXEL_FRAME_READBACK_EN
  logic [AW-1:0]   RD_ROW, RD_COL;
  logic            RD_DATA;
`endif

  always #5 CLK = ~CLK;

  pixel_frame_writer #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .WR_VALID (WR_VALID),
    .WR_READY (WR_READY),
    .WR_ROW   (WR_ROW),
    .WR_COL   (WR_COL),
    .WR_DATA  (WR_DATA),
    .CLR_REQ  (CLR_REQ),
    .SWAP_REQ (SWAP_REQ),
    .FRAME    (FRAME),
    .BUSY     (BUSY),
    .ERR      (ERR),
`ifdef PIXEL_FRAME_READBACK_EN
    .RD_ROW   (RD_ROW),
    .RD_COL   (RD_COL),
    .RD_DATA  (RD_DATA),
`endif
    .ERR_CLR  (ERR_CLR)
  );

  int unsigned     total  = 0;
  int unsigned     passes = 0;
  int unsigned     fails  = 0;
  logic [NPIX-1:0] m_back, m_frame;
  logic            m_err;
  logic [NPIX-1:0] exp_q[$];
  int              n;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input int r, input int c);
    return (r >= 1) && (r <= int'(ROWS)) && (c >= 1) && (c <= int'(COLS));
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One write handshake; optional same-cycle clear/swap requests.
  task automatic wr(input int r, input int c, input logic d, input logic clr, input logic swp);
    WR_VALID = 1'b1;
    WR_ROW   = AW'(r);
    WR_COL   = AW'(c);
    WR_DATA  = d;
    CLR_REQ  = clr;
    SWAP_REQ = swp;
    check("wr_ready", 64'(WR_READY), 64'd1);
    if (legal(r, c)) m_back[(r - 1) * int'(COLS) + (c - 1)] = d;
    else m_err = 1'b1;
    if (ERR_CLR) m_err = 1'b0;
    if (clr) m_back = '0;
    if (swp) exp_q.push_back(m_back);
    tick();
    WR_VALID = 1'b0;
    CLR_REQ  = 1'b0;
    SWAP_REQ = 1'b0;
    check("err_flag", 64'(ERR), 64'(m_err));
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (BUSY === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask

  task automatic pop_check(input string tag);
    check("sb_pending", 64'(exp_q.size()), 64'd1);
    if (exp_q.size() != 0) begin
      m_frame = exp_q.pop_front();
      check(tag, 64'(FRAME), 64'(m_frame));
    end
  endtask

  task automatic swap_commit();
    int cnt;
    SWAP_REQ = 1'b1;
    exp_q.push_back(m_back);
    tick();
    SWAP_REQ = 1'b0;
    check("frame_hold_in_commit", 64'(FRAME), 64'(m_frame));
    wait_idle(cnt);
    check("commit_cycles", 64'(cnt), 64'd1);
    pop_check("frame_after_commit");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RESET_N = 1'b0; WR_VALID = 1'b0; WR_DATA = 1'b0; WR_ROW = '0; WR_COL = '0;
    CLR_REQ = 1'b0; SWAP_REQ = 1'b0; ERR_CLR = 1'b0;
`ifdef PIXEL_FRAME_READBACK_EN
    RD_ROW = '0; RD_COL = '0;
`endif
    m_back = '0; m_frame = '0; m_err = 1'b0;
    tick();
    tick();
    check("reset_frame", 64'(FRAME), 64'd0);
    check("reset_ready", 64'(WR_READY), 64'd0);
    check("reset_busy", 64'(BUSY), 64'd0);
    check("reset_err", 64'(ERR), 64'd0);
    RESET_N = 1'b1;
    tick();
    check("ready_after_reset", 64'(WR_READY), 64'd1);

    // single pixel, visible only after commit
    wr(3, 4, 1'b1, 1'b0, 1'b0);
    check("frame_before_swap", 64'(FRAME), 64'd0);
    swap_commit();
    check("frame_px_3_4", 64'(FRAME), 64'h2_0000);

    // corners
    wr(3, 4, 1'b0, 1'b0, 1'b0);
    wr(1, 1, 1'b1, 1'b0, 1'b0);
    wr(5, 7, 1'b1, 1'b0, 1'b0);
    swap_commit();
    check("frame_corners", 64'(FRAME), 64'h4_0000_0001);

    // illegal addresses and sticky error
    wr(0, 2, 1'b1, 1'b0, 1'b0);
    check("frame_after_illegal", 64'(FRAME), 64'h4_0000_0001);
    ERR_CLR = 1'b1; m_err = 1'b0;
    tick();
    check("err_cleared", 64'(ERR), 64'd0);
    wr(6, 1, 1'b1, 1'b0, 1'b0);  // ERR_CLR still high: clear wins
    ERR_CLR = 1'b0;
    wr(1, 0, 1'b1, 1'b0, 1'b0);
    ERR_CLR = 1'b1; m_err = 1'b0;
    tick();
    ERR_CLR = 1'b0;
    swap_commit();

    // fill, commit, then a plain clear
    for (int r = 1; r <= int'(ROWS); r++)
      for (int c = 1; c <= int'(COLS); c++)
        wr(r, c, 1'b1, 1'b0, 1'b0);
    swap_commit();
    check("frame_all_ones", 64'(FRAME), 64'h7_FFFF_FFFF);
    CLR_REQ = 1'b1;
    tick();
    CLR_REQ = 1'b0;
    m_back = '0;
    n = 0;
    while (BUSY === 1'b1 && n < 100) begin
      if (n == 20) begin
        check("ready_low_in_clear", 64'(WR_READY), 64'd0);
        check("frame_hold_in_clear", 64'(FRAME), 64'h7_FFFF_FFFF);
      end
      tick();
      n++;
    end
    check("clear_cycles", 64'(n), 64'd35);
    check("frame_after_clear", 64'(FRAME), 64'h7_FFFF_FFFF);
    check("ready_after_clear", 64'(WR_READY), 64'd1);
    swap_commit();
    check("frame_zero_after_swap", 64'(FRAME), 64'd0);

    // swap requested on cycle 10 of a clear
    wr(2, 3, 1'b1, 1'b0, 1'b0);
    wr(4, 5, 1'b1, 1'b0, 1'b0);
    swap_commit();
    CLR_REQ = 1'b1;
    tick();
    CLR_REQ = 1'b0;
    m_back = '0;
    n = 0;
    while (BUSY === 1'b1 && n < 100) begin
      SWAP_REQ = (n == 9);
      if (SWAP_REQ) exp_q.push_back(m_back);
      if (n == 20) check("frame_hold_pending", 64'(FRAME), 64'(m_frame));
      tick();
      n++;
    end
    SWAP_REQ = 1'b0;
    check("clear_swap_cycles", 64'(n), 64'd36);
    pop_check("frame_after_pending_swap");

    // write and swap in the same cycle
    wr(2, 6, 1'b1, 1'b0, 1'b1);
    check("frame_hold_write_swap", 64'(FRAME), 64'd0);
    wait_idle(n);
    pop_check("frame_write_swap");
    check("frame_px_2_6", 64'(FRAME), 64'h1000);

    // write + clear + swap together: clear first, then commit of zeros
    wr(1, 1, 1'b1, 1'b1, 1'b1);
    wait_idle(n);
    check("clr_swap_cycles", 64'(n), 64'd36);
    pop_check("frame_clr_swap");

    // reset in the middle of a clear
    wr(5, 5, 1'b1, 1'b0, 1'b0);
    swap_commit();
    wr(0, 0, 1'b1, 1'b0, 1'b0);
    CLR_REQ = 1'b1;
    tick();
    CLR_REQ = 1'b0;
    repeat (5) tick();
    #2;
    RESET_N = 1'b0;
    #1;
    check("async_rst_frame", 64'(FRAME), 64'd0);
    check("async_rst_busy", 64'(BUSY), 64'd0);
    check("async_rst_ready", 64'(WR_READY), 64'd0);
    check("async_rst_err", 64'(ERR), 64'd0);
    m_back = '0; m_frame = '0; m_err = 1'b0;
    exp_q.delete();
    tick();
    RESET_N = 1'b1;
    tick();
    check("ready_after_rst2", 64'(WR_READY), 64'd1);
    check("busy_after_rst2", 64'(BUSY), 64'd0);
    swap_commit();
    check("back_zero_after_rst", 64'(FRAME), 64'd0);

`ifdef PIXEL_FRAME_READBACK_EN
    RD_ROW = AW'(4);
    RD_COL = AW'(2);
    wr(4, 2, 1'b1, 1'b0, 1'b0);
    check("rd_same_cycle_old", 64'(RD_DATA), 64'd0);
    tick();
    check("rd_4_2", 64'(RD_DATA), 64'd1);
    RD_ROW = AW'(6);
    RD_COL = AW'(1);
    tick();
    check("rd_illegal", 64'(RD_DATA), 64'd0);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
